// File: rtl/pipe_ctrl.sv
// Hazard unit for a 5-stage pipeline: load-use stall, branch flush, ALU forwarding, data-memory wait FSM.
// Latency: all stall/flush/forward outputs are combinational (zero cycle); state, wait counter, timeout and stall count are registered.
// Backpressure: a pending data-memory access holds F/D/E/M and bubbles W; a wait of 16+ cycles latches a timeout that holds the pipe until reset.
module pipe_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs1_d_i,
  input  logic [4:0]  rs2_d_i,
  input  logic [4:0]  rs1_e_i,
  input  logic [4:0]  rs2_e_i,
  input  logic [4:0]  rd_e_i,
  input  logic        load_e_i,
  input  logic        pc_src_e_i,
  input  logic [4:0]  rd_m_i,
  input  logic        reg_write_m_i,
  input  logic [4:0]  rd_w_i,
  input  logic        reg_write_w_i,
  input  logic        mem_req_m_i,
  input  logic        mem_ready_i,
  output logic        stall_f_o,
  output logic        stall_d_o,
  output logic        stall_e_o,
  output logic        stall_m_o,
  output logic        flush_d_o,
  output logic        flush_e_o,
  output logic        flush_w_o,
  output logic [1:0]  forward_a_e_o,
  output logic [1:0]  forward_b_e_o,
  output logic        mem_timeout_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t      state_q, state_nxt;
  logic [3:0]  wait_q, wait_nxt;
  logic        timeout_q, timeout_nxt;
  logic [15:0] stall_cnt_q;
  logic        mem_stall;
  logic        lw_stall;

  // Memory stall follows the handshake, except a timed-out access pins the pipe.
  assign mem_stall = (state_q == ERROR) ? 1'b1 : (mem_req_m_i & ~mem_ready_i);

  // Load-use hazard: Decode reads the register a load in Execute has not produced yet; x0 never hazards.
  assign lw_stall = load_e_i & (rd_e_i != 5'd0) & ((rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i));

  // Flushes are gated by mem_stall so a held stage is never cleared; they land when the pipe advances.
  assign stall_f_o = mem_stall | lw_stall;
  assign stall_d_o = mem_stall | lw_stall;
  assign stall_e_o = mem_stall;
  assign stall_m_o = mem_stall;
  assign flush_w_o = mem_stall;
  assign flush_d_o = pc_src_e_i & ~mem_stall;
  assign flush_e_o = (lw_stall | pc_src_e_i) & ~mem_stall;

  // Operand forwarding: Memory-stage result is newer than Writeback, so it wins.
  always_comb begin
    forward_a_e_o = 2'b00;
    forward_b_e_o = 2'b00;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs1_e_i))
      forward_a_e_o = 2'b10;
    else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs1_e_i))
      forward_a_e_o = 2'b01;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs2_e_i))
      forward_b_e_o = 2'b10;
    else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs2_e_i))
      forward_b_e_o = 2'b01;
  end

  // Memory-wait FSM next state: count cycles spent waiting, give up after the 16th.
  always_comb begin
    state_nxt   = state_q;
    wait_nxt    = wait_q;
    timeout_nxt = timeout_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 4'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          state_nxt = RUN;
          wait_nxt  = 4'd0;
        end else if (wait_q == 4'd15) begin
          state_nxt   = ERROR;
          timeout_nxt = 1'b1;
        end else begin
          wait_nxt = wait_q + 4'd1;
        end
      end
      ERROR: begin
        timeout_nxt = 1'b1;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = 4'd0;
      end
    endcase
  end

  // FSM registers; reset drops any wait or error immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      wait_q    <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      wait_q    <= wait_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Stalled-cycle counter, saturating so a long hang reads as "at least 65535".
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_q <= 16'd0;
    else if (stall_f_o && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign mem_timeout_o = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset. Clock `clk_i` is rising-edge; reset `rst_i` asserts asynchronously.
REQ-002 SHALL have `clk_i` as input, 1 bit: pipeline clock.
REQ-003 SHALL have `rst_i` as input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have `rs1_d_i` and `rs2_d_i` as inputs, 5 bits each: source registers in Decode.
REQ-005 SHALL have `rs1_e_i`, `rs2_e_i` and `rd_e_i` as inputs, 5 bits each: source and destination registers in Execute.
REQ-006 SHALL have `load_e_i` as input, 1 bit: the Execute instruction is a load (result_src_e == 01).
REQ-007 SHALL have `pc_src_e_i` as input, 1 bit: branch or jump taken in Execute.
REQ-008 SHALL have `rd_m_i` (5 bits) and `reg_write_m_i` (1 bit) as inputs: Memory-stage destination and write enable.
REQ-009 SHALL have `rd_w_i` (5 bits) and `reg_write_w_i` (1 bit) as inputs: Writeback-stage destination and write enable.
REQ-010 SHALL have `mem_req_m_i` as input, 1 bit: a load or store is in Memory.
REQ-011 SHALL have `mem_ready_i` as input, 1 bit: data memory completes the access this cycle.
REQ-012 SHALL have `stall_f_o`, `stall_d_o`, `stall_e_o` and `stall_m_o` as outputs, 1 bit each: hold the F/D/E/M pipeline registers.
REQ-013 SHALL have `flush_d_o`, `flush_e_o` and `flush_w_o` as outputs, 1 bit each: clear the D/E/W pipeline registers to a bubble.
REQ-014 SHALL have `forward_a_e_o` and `forward_b_e_o` as outputs, 2 bits each: ALU operand select. 00 selects the register file, 10 selects alu_result_m, 01 selects result_w.
REQ-015 SHALL have `mem_timeout_o` as output, 1 bit: sticky data-memory timeout error.
REQ-016 SHALL have `stall_cnt_o` as output, 16 bits: saturating count of stalled cycles.

Function
REQ-017 SHALL implement a state machine with states RUN, MEM_WAIT and ERROR.
REQ-018 SHALL assert `mem_stall` = `mem_req_m_i` & ~`mem_ready_i` combinationally in RUN and in MEM_WAIT.
REQ-019 SHALL force `mem_stall` = 1 in ERROR.
REQ-020 SHALL transition RUN->MEM_WAIT when `mem_stall` is 1, and load wait counter = 1.
REQ-021 SHALL, in MEM_WAIT, transition to RUN when `mem_ready_i` = 1.
REQ-022 SHALL, in MEM_WAIT, otherwise increment the 4-bit wait counter.
REQ-023 SHALL, in MEM_WAIT, transition to ERROR when the counter = 15 and `mem_ready_i` = 0.
REQ-024 SHALL remain in ERROR until reset, with `mem_timeout_o` = 1.
REQ-025 SHALL compute `lw_stall` = `load_e_i` & (`rd_e_i` != 0) & (`rd_e_i` == `rs1_d_i` | `rd_e_i` == `rs2_d_i`).
REQ-026 SHALL drive `stall_f_o` = `stall_d_o` = `mem_stall` | `lw_stall`.
REQ-027 SHALL drive `stall_e_o` = `stall_m_o` = `mem_stall`.
REQ-028 SHALL drive `flush_w_o` = `mem_stall`, so a bubble enters Writeback while Memory waits.
REQ-029 SHALL drive `flush_d_o` = `pc_src_e_i` & ~`mem_stall`.
REQ-030 SHALL drive `flush_e_o` = (`lw_stall` | `pc_src_e_i`) & ~`mem_stall`, so a held Execute is never cleared and the flush is applied on the cycle the pipe advances.
REQ-031 SHALL, when `lw_stall` and `pc_src_e_i` are both 1, flush D and E and also stall F and D.
REQ-032 SHALL compute forward A as 10 if `reg_write_m_i` & `rd_m_i` != 0 & `rd_m_i` == `rs1_e_i`.
REQ-033 SHALL otherwise compute forward A as 01 if `reg_write_w_i` & `rd_w_i` != 0 & `rd_w_i` == `rs1_e_i`.
REQ-034 SHALL otherwise compute forward A as 00.
REQ-035 SHALL compute forward B identically using `rs2_e_i`, with Memory taking priority over Writeback.
REQ-036 SHALL keep forwarding combinational and valid in every state.
REQ-037 SHALL increment `stall_cnt_o` on each rising edge where `stall_f_o` = 1, saturating at 0xFFFF with no wrap.
REQ-038 SHALL produce zero-latency combinational control outputs; only the state, wait counter, `mem_timeout_o` and `stall_cnt_o` are registered.

Reset
REQ-039 SHALL, while `rst_i` = 1, set state = RUN, wait counter = 0, `mem_timeout_o` = 0 and `stall_cnt_o` = 0 immediately, independent of `clk_i`.
REQ-040 SHALL, on reset asserted in MEM_WAIT or ERROR, abort the wait with no residual stall: combinational outputs follow inputs as in RUN.
REQ-041 SHALL take the first state update on the first rising edge after `rst_i` deasserts.

Verification
REQ-042 SHALL verify load-use: `load_e_i`=1, `rd_e_i`=5, `rs1_d_i`=5 -> `stall_f_o`=`stall_d_o`=`flush_e_o`=1, `flush_d_o`=0, and `stall_cnt_o` increments by 1.
REQ-043 SHALL verify forwarding priority: `rd_m_i`=`rd_w_i`=`rs2_e_i`=7, both write enables 1 -> `forward_b_e_o`=10; with `rd_m_i`=0 -> `forward_b_e_o`=01.
REQ-044 SHALL verify the x0 guard: `rd_m_i`=0=`rs1_e_i` with `reg_write_m_i`=1 -> `forward_a_e_o`=00.
REQ-045 SHALL verify a memory wait: `mem_req_m_i`=1, `mem_ready_i`=0 for 3 cycles then 1 -> all stalls and `flush_w_o` =1 for 3 cycles, state returns to RUN, and a concurrent `pc_src_e_i`=1 causes a flush only on the 4th cycle.
REQ-046 SHALL verify timeout: `mem_ready_i` held 0 for 16 cycles -> `mem_timeout_o`=1 and all stalls stay 1 after `mem_ready_i` rises; asserting `rst_i` -> `mem_timeout_o`=0 and the stalls release asynchronously.
REQ-047 SHALL verify saturation: force 70000 stalled cycles -> `stall_cnt_o`=0xFFFF and holds.
